mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the core control path (fetch, load, store) and the boot loader/debug path (program load, memory inspect).
- Each requester gets a req/gnt/rvalid handshake.
- The arbiter latches the winning request, drives the memory port, waits a fixed memory latency, then returns read data or a write acknowledge to the owner.
- It sits between the core's address/write-enable mux and the memory macro.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; the byte mask is DATA_W/8 bits.
- LATENCY, 1, cycles from the issue cycle until mem_rdata is valid; legal values 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- core_req  input  1  core requests an access; held until core_gnt.
- core_addr  input  ADDR_W  core byte address.
- core_wdata  input  DATA_W  core store data.
- core_we  input  DATA_W/8  core byte write mask; 0 means read.
- core_gnt  output  1  one-cycle pulse: core request accepted and latched.
- core_rvalid  output  1  one-cycle pulse: core access complete; core_rdata valid.
- core_rdata  output  DATA_W  read data for the core.
- ldr_req, ldr_addr, ldr_wdata, ldr_we  input  1/ADDR_W/DATA_W/DATA_W/8  loader request; same rules as core.
- ldr_gnt, ldr_rvalid  output  1  loader grant and completion pulses.
- ldr_rdata  output  DATA_W  read data for the loader.
- mem_en  output  1  memory access strobe, high for exactly one cycle (ISSUE).
- mem_addr  output  ADDR_W  latched address.
- mem_wdata  output  DATA_W  latched write data.
- mem_we  output  DATA_W/8  latched byte mask; gated by mem_en.
- mem_rdata  input  DATA_W  memory read data, valid LATENCY cycles after the issue cycle.
- busy  output  1  high in any state other than IDLE.
- owner  output  1  current owner: 0 = core, 1 = loader; holds its last value in IDLE.

Behaviour:
- Reset (async): state = IDLE, counter = 0, owner = 0, last_served = loader; all outputs 0. An in-flight access is abandoned and mem_en drops immediately.
- State machine: IDLE -> ISSUE -> (WAIT)* -> DONE -> IDLE.
- IDLE:
  - If either request is high, select a winner and assert its gnt combinationally this cycle.
  - Latch that requester's addr/wdata/we into internal registers, set owner, go to ISSUE.
  - No request: stay in IDLE.
- Arbitration when both request: core wins (fixed priority). A loser keeps req high and is granted in a later IDLE.
- ISSUE:
  - mem_en = 1; mem_addr/mem_wdata/mem_we come from the latched registers.
  - LATENCY = 1: go to DONE. Otherwise load counter = LATENCY-1 and go to WAIT.
- WAIT: mem_en = 0, mem_we = 0; decrement counter; when counter == 1 go to DONE.
- DONE:
  - Owner's rvalid = 1; owner's rdata = mem_rdata (pass-through).
  - For writes, rvalid is a completion ack and rdata is don't-care.
  - Update last_served = owner; go to IDLE.
- Timing: with gnt in cycle T, issue is in T+1 and rvalid is in T+1+LATENCY. Back-to-back throughput is one access per LATENCY+2 cycles.
- Non-owner outputs: the non-owner's gnt, rvalid and rdata are 0 at all times.
- Requests raised in ISSUE, WAIT or DONE are ignored until IDLE; no gnt is issued outside IDLE.
- Requesters must not change addr/wdata/we between raising req and seeing gnt. Dropping req before gnt withdraws the request.
- After gnt the arbiter uses only latched values, so requester inputs may change freely.
- Re-assert req in the same cycle as rvalid: evaluated in the next IDLE cycle.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the requester that is not last_served wins. Because last_served resets to loader, the first tie goes to the core; ties then alternate.
- Undefined: fixed core priority; the last_served register is not built.

Decomposition:
- Shared package (types.svh): arb_state_t enum (ARB_STATE__IDLE, __ISSUE, __WAIT, __DONE) and arb_owner_t enum (ARB_OWNER__CORE, ARB_OWNER__LDR).
- params.svh: default MEM_LATENCY constant.
- One natural sub-module: mem_arb_wait_ctr, a 4-bit loadable down-counter with load/dec/is_one outputs. Everything else lives in the top module.

Test Plan:
- Reset behaviour: assert reset mid-WAIT (LATENCY=3) -> busy=0, mem_en=0, state IDLE in the same cycle; no rvalid pulse after release.
- Single core read: LATENCY=1, core_req with addr 0x0000_0010, we=0, mem returns 0xDEAD_BEEF -> core_gnt at T, mem_en at T+1 with addr 0x10, core_rvalid at T+2 with core_rdata=0xDEAD_BEEF.
- Loader byte write: LATENCY=2, ldr_req with addr 0x0000_0104, wdata 0x0000_00AB, we=4'b0001 -> mem_we=4'b0001 only in the issue cycle, ldr_rvalid at T+3, core outputs stay 0.
- Simultaneous requests, fixed priority: both req held high for 3 transactions -> three core grants, zero loader grants.
- Simultaneous requests with MEM_ARB_ROUND_ROBIN_EN: both req held high for 4 transactions -> grant order core, ldr, core, ldr.
- Late arrival: core_req raised during WAIT -> no gnt until IDLE; gnt comes in the cycle after the DONE rvalid, and the latched address is unchanged if core_addr toggles after gnt.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_LATENCY = 1;
  localparam int unsigned CTR_W       = 4;

  typedef enum logic [1:0] {
    ARB_STATE__IDLE,
    ARB_STATE__ISSUE,
    ARB_STATE__WAIT,
    ARB_STATE__DONE
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER__CORE = 1'b0,
    ARB_OWNER__LDR  = 1'b1
  } arb_owner_t;

  // Winner selection; on a tie, rr_en hands the port to whoever was not served last.
  function automatic arb_owner_t arb_pick(input logic       core_req,
                                          input logic       ldr_req,
                                          input arb_owner_t last_served,
                                          input logic       rr_en);
    arb_owner_t win;
    win = ARB_OWNER__CORE;
    if (ldr_req && !core_req) begin
      win = ARB_OWNER__LDR;
    end else if (ldr_req && core_req && rr_en) begin
      win = (last_served == ARB_OWNER__CORE) ? ARB_OWNER__LDR : ARB_OWNER__CORE;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Loadable 4-bit down-counter that times the memory latency window.
module mem_arb_wait_ctr
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [CTR_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign is_one = (count_q == CTR_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (core / loader) for the shared instruction/data memory port.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate winners on simultaneous requests.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = MEM_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_req,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_we,
  output logic                core_gnt,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  input  logic                ldr_req,
  input  logic [ADDR_W-1:0]   ldr_addr,
  input  logic [DATA_W-1:0]   ldr_wdata,
  input  logic [DATA_W/8-1:0] ldr_we,
  output logic                ldr_gnt,
  output logic                ldr_rvalid,
  output logic [DATA_W-1:0]   ldr_rdata,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam bit SingleCycle = (LATENCY == 1);
  localparam logic [CTR_W-1:0] WaitLoad = CTR_W'(LATENCY - 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        winner;
  arb_owner_t        last_served;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   we_q, we_d;
  logic              ctr_load, ctr_dec, ctr_is_one;
  logic              rr_en;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_t last_served_q, last_served_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_served_q <= ARB_OWNER__LDR;
    end else begin
      last_served_q <= last_served_d;
    end
  end

  always_comb begin
    last_served_d = last_served_q;
    if (state_q == ARB_STATE__DONE) begin
      last_served_d = owner_q;
    end
  end

  assign last_served = last_served_q;
  assign rr_en       = 1'b1;
`else
  assign last_served = ARB_OWNER__LDR;
  assign rr_en       = 1'b0;
`endif

  assign winner = arb_pick(core_req, ldr_req, last_served, rr_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_STATE__IDLE;
      owner_q <= ARB_OWNER__CORE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    core_gnt = 1'b0;
    ldr_gnt  = 1'b0;
    mem_en   = 1'b0;
    unique case (state_q)
      ARB_STATE__IDLE: begin
        if (core_req || ldr_req) begin
          owner_d = winner;
          state_d = ARB_STATE__ISSUE;
          if (winner == ARB_OWNER__CORE) begin
            core_gnt = 1'b1;
            addr_d   = core_addr;
            wdata_d  = core_wdata;
            we_d     = core_we;
          end else begin
            ldr_gnt = 1'b1;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
            we_d    = ldr_we;
          end
        end
      end
      ARB_STATE__ISSUE: begin
        mem_en = 1'b1;
        if (SingleCycle) begin
          state_d = ARB_STATE__DONE;
        end else begin
          ctr_load = 1'b1;
          state_d  = ARB_STATE__WAIT;
        end
      end
      ARB_STATE__WAIT: begin
        ctr_dec = 1'b1;
        if (ctr_is_one) begin
          state_d = ARB_STATE__DONE;
        end
      end
      ARB_STATE__DONE: begin
        state_d = ARB_STATE__IDLE;
      end
      default: begin
        state_d = ARB_STATE__IDLE;
      end
    endcase
  end

  mem_arb_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (WaitLoad),
    .dec      (ctr_dec),
    .is_one   (ctr_is_one)
  );

  // Completion is a pure pass-through of mem_rdata, steered to the owner only.
  always_comb begin
    core_rvalid = (state_q == ARB_STATE__DONE) && (owner_q == ARB_OWNER__CORE);
    ldr_rvalid  = (state_q == ARB_STATE__DONE) && (owner_q == ARB_OWNER__LDR);
    core_rdata  = core_rvalid ? mem_rdata : '0;
    ldr_rdata   = ldr_rvalid ? mem_rdata : '0;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_en ? we_q : '0;
  assign busy      = (state_q != ARB_STATE__IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: LATENCY=3 main instance plus a LATENCY=1 instance.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 3;

  typedef struct packed {
    logic        is_ldr;
    logic        is_write;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, ldr_req = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0, ldr_addr = '0, ldr_wdata = '0;
  logic [3:0]  core_we = '0, ldr_we = '0;
  logic        core_gnt, core_rvalid, ldr_gnt, ldr_rvalid;
  logic [31:0] core_rdata, ldr_rdata;
  logic        mem_en, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  // Second instance, LATENCY=1
  logic        c1_req = 1'b0;
  logic [31:0] c1_addr = '0;
  logic        c1_gnt, c1_rvalid, l1_gnt, l1_rvalid, m1_en, busy1, owner1;
  logic [31:0] c1_rdata, l1_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_we;
  logic        m1_valid;
  logic [31:0] m1_data;

  int   n_pass = 0, n_total = 0, cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_we(ldr_we),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .core_req(c1_req), .core_addr(c1_addr), .core_wdata(32'h0), .core_we(4'h0),
    .core_gnt(c1_gnt), .core_rvalid(c1_rvalid), .core_rdata(c1_rdata),
    .ldr_req(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0), .ldr_we(4'h0),
    .ldr_gnt(l1_gnt), .ldr_rvalid(l1_rvalid), .ldr_rdata(l1_rdata),
    .mem_en(m1_en), .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_we(m1_we),
    .mem_rdata(m1_rdata), .busy(busy1), .owner(owner1)
  );

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    if (idx == 8'h04) return 32'hDEAD_BEEF;
    if (idx == 8'h41) return 32'h1122_3344;
    return {8'hC0, idx, ~idx, 8'h5A};
  endfunction

  // Memory model: read data is valid exactly LAT cycles after the issue cycle, garbage otherwise.
  logic [31:0] mem [256];
  logic [31:0] pend_data;
  int          pend_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
      pend_cnt  <= 0;
      pend_data <= '0;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      pend_data <= mem[mem_addr[9:2]];
      pend_cnt  <= LAT;
    end else if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end
  assign mem_rdata = (pend_cnt == 1) ? pend_data : 32'h0BAD_0BAD;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m1_valid <= 1'b0;
      m1_data  <= '0;
    end else begin
      m1_valid <= m1_en;
      m1_data  <= init_word(m1_addr[9:2]);
    end
  end
  assign m1_rdata = m1_valid ? m1_data : 32'h0BAD_0BAD;

  task automatic wait_gnt(output bit c, output bit l);
    bit seen;
    c = 0; l = 0; seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (core_gnt || ldr_gnt) begin
        c = core_gnt; l = ldr_gnt; seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bit c, l;
    int rv;
    @(negedge clk); @(negedge clk);
    n_total++;
    if ({busy, mem_en, owner, core_gnt, ldr_gnt, core_rvalid, ldr_rvalid} !== 7'b0)
      $display("FAIL reset_outputs: got %b want 0000000",
               {busy, mem_en, owner, core_gnt, ldr_gnt, core_rvalid, ldr_rvalid});
    else n_pass++;
    @(posedge clk); #1; reset = 0;
    core_addr = 32'h8; core_we = 4'h0; core_req = 1;
    wait_gnt(c, l);
    @(posedge clk); #1; core_req = 0;
    @(posedge clk); #1;
    #2 reset = 1;
    #1;
    n_total++;
    if ({busy, mem_en, owner} !== 3'b000)
      $display("FAIL reset_mid_wait: got busy/mem_en/owner %b want 000", {busy, mem_en, owner});
    else n_pass++;
    @(posedge clk); #1; reset = 0;
    rv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (core_rvalid || ldr_rvalid || busy) rv++;
      @(posedge clk); #1;
    end
    n_total++;
    if (rv !== 0) $display("FAIL reset_no_rvalid: got %0d active cycles want 0", rv);
    else n_pass++;
  endtask

  task automatic test_single_read();
    bit   c, l;
    exp_t e;
    core_addr = 32'h10; core_we = 4'h0; core_wdata = 32'h0; core_req = 1;
    wait_gnt(c, l);
    n_total++;
    if ({c, l} !== 2'b10) $display("FAIL read_gnt: got core/ldr %b want 10", {c, l});
    else n_pass++;
    sb.push_back('{is_ldr: 1'b0, is_write: 1'b0, data: mem[8'h04]});
    @(posedge clk); #1; core_req = 0;
    @(negedge clk);
    n_total++;
    if ({mem_en, mem_we, busy, owner} !== 7'b1_0000_1_0 || mem_addr !== 32'h10)
      $display("FAIL read_issue: got en/we/busy/owner %b addr %h want 1000010 addr 00000010",
               {mem_en, mem_we, busy, owner}, mem_addr);
    else n_pass++;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_total++;
      if (core_rvalid !== (k == LAT) || ldr_rvalid !== 1'b0 || mem_en !== 1'b0)
        $display("FAIL read_rvalid_t%0d: got core_rvalid %b ldr_rvalid %b mem_en %b want %b 0 0",
                 k, core_rvalid, ldr_rvalid, mem_en, (k == LAT));
      else n_pass++;
      if (core_rvalid && sb.size() != 0) begin
        e = sb.pop_front();
        n_total++;
        if (e.is_ldr !== 1'b0 || core_rdata !== e.data)
          $display("FAIL read_data: got %h want %h", core_rdata, e.data);
        else n_pass++;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL read_back_idle: got busy %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_latency1_read();
    bit seen = 0;
    c1_addr = 32'h10; c1_req = 1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (c1_gnt) seen = 1;
      else begin @(posedge clk); #1; end
    end
    n_total++;
    if (!seen) $display("FAIL lat1_gnt: got no grant want grant");
    else n_pass++;
    @(posedge clk); #1; c1_req = 0;
    @(negedge clk);
    n_total++;
    if (m1_en !== 1'b1 || m1_addr !== 32'h10 || c1_rvalid !== 1'b0)
      $display("FAIL lat1_issue: got en %b addr %h rvalid %b want 1 00000010 0",
               m1_en, m1_addr, c1_rvalid);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (c1_rvalid !== 1'b1 || c1_rdata !== 32'hDEAD_BEEF || l1_rvalid !== 1'b0)
      $display("FAIL lat1_rvalid: got rvalid %b rdata %h want 1 deadbeef", c1_rvalid, c1_rdata);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({busy1, c1_rvalid, l1_gnt, owner1} !== 4'b0)
      $display("FAIL lat1_idle: got busy/rvalid/lgnt/owner %b want 0000",
               {busy1, c1_rvalid, l1_gnt, owner1});
    else n_pass++;
  endtask

  task automatic test_ldr_write();
    bit   c, l, core_bad;
    exp_t e;
    core_bad = 0;
    ldr_addr = 32'h104; ldr_wdata = 32'h0000_00AB; ldr_we = 4'b0001; ldr_req = 1;
    wait_gnt(c, l);
    n_total++;
    if ({c, l} !== 2'b01) $display("FAIL wr_gnt: got core/ldr %b want 01", {c, l});
    else n_pass++;
    sb.push_back('{is_ldr: 1'b1, is_write: 1'b1, data: 32'h0});
    @(posedge clk); #1; ldr_req = 0; ldr_we = 4'b1111; ldr_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_total++;
    if (mem_en !== 1'b1 || mem_we !== 4'b0001 || mem_addr !== 32'h104 || owner !== 1'b1)
      $display("FAIL wr_issue: got en %b we %b addr %h owner %b want 1 0001 00000104 1",
               mem_en, mem_we, mem_addr, owner);
    else n_pass++;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (core_gnt || core_rvalid || core_rdata !== 32'h0) core_bad = 1;
      n_total++;
      if (ldr_rvalid !== (k == LAT) || mem_we !== 4'b0)
        $display("FAIL wr_cycle_t%0d: got ldr_rvalid %b mem_we %b want %b 0000",
                 k, ldr_rvalid, mem_we, (k == LAT));
      else n_pass++;
      if (ldr_rvalid && sb.size() != 0) begin
        e = sb.pop_front();
        n_total++;
        if (e.is_ldr !== 1'b1) $display("FAIL wr_owner: got core want ldr");
        else n_pass++;
      end
    end
    n_total++;
    if (core_bad) $display("FAIL wr_core_quiet: got core activity want none");
    else n_pass++;
    n_total++;
    if (mem[8'h41] !== 32'h1122_33AB)
      $display("FAIL wr_mem: got %h want 112233ab", mem[8'h41]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit   c, l, exp_l, bad;
    int   last_cyc;
    exp_t e;
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    core_addr = 32'h20; core_we = 4'h0; ldr_addr = 32'h30; ldr_we = 4'h0;
    core_req = 1; ldr_req = 1;
    last_cyc = 0;
    for (int n = 0; n < 4; n++) begin
      wait_gnt(c, l);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_l = n[0];
`else
      exp_l = 1'b0;
`endif
      n_total++;
      if ({c, l} !== {~exp_l, exp_l})
        $display("FAIL tie_order_%0d: got core/ldr %b want %b", n, {c, l}, {~exp_l, exp_l});
      else n_pass++;
      if (n > 0) begin
        n_total++;
        if (cyc - last_cyc !== LAT + 2)
          $display("FAIL tie_spacing_%0d: got %0d want %0d", n, cyc - last_cyc, LAT + 2);
        else n_pass++;
      end
      last_cyc = cyc;
      sb.push_back('{is_ldr: l, is_write: 1'b0, data: l ? mem[8'h0C] : mem[8'h08]});
      bad = 0;
      for (int k = 1; k <= LAT + 1; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (core_gnt || ldr_gnt) bad = 1;
        if (k == LAT + 1 && sb.size() != 0) begin
          e = sb.pop_front();
          n_total++;
          if ({core_rvalid, ldr_rvalid} !== {~e.is_ldr, e.is_ldr} ||
              (e.is_ldr ? ldr_rdata : core_rdata) !== e.data)
            $display("FAIL tie_done_%0d: got rvalid %b data %h want %b %h", n,
                     {core_rvalid, ldr_rvalid}, e.is_ldr ? ldr_rdata : core_rdata,
                     {~e.is_ldr, e.is_ldr}, e.data);
          else n_pass++;
        end
      end
      n_total++;
      if (bad) $display("FAIL tie_gnt_busy_%0d: got gnt outside idle want none", n);
      else n_pass++;
      @(posedge clk); #1;
    end
    core_req = 0; ldr_req = 0;
  endtask

  task automatic test_late_arrival();
    bit   c, l, late_bad;
    exp_t e;
    ldr_addr = 32'h60; ldr_we = 4'h0; ldr_req = 1;
    wait_gnt(c, l);
    sb.push_back('{is_ldr: 1'b1, is_write: 1'b0, data: mem[8'h18]});
    @(posedge clk); #1; ldr_req = 0;
    @(posedge clk); #1; core_addr = 32'h50; core_we = 4'h0; core_req = 1;
    late_bad = 0;
    for (int k = 1; k <= LAT; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      if (core_gnt) late_bad = 1;
      if (k == LAT && sb.size() != 0) begin
        e = sb.pop_front();
        n_total++;
        if (ldr_rvalid !== 1'b1 || ldr_rdata !== e.data)
          $display("FAIL late_ldr_done: got rvalid %b data %h want 1 %h",
                   ldr_rvalid, ldr_rdata, e.data);
        else n_pass++;
      end
    end
    n_total++;
    if (late_bad) $display("FAIL late_no_early_gnt: got gnt before idle want none");
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (core_gnt !== 1'b1) $display("FAIL late_gnt: got %b want 1", core_gnt);
    else n_pass++;
    sb.push_back('{is_ldr: 1'b0, is_write: 1'b0, data: mem[8'h14]});
    @(posedge clk); #1; core_addr = 32'h54; core_req = 0;
    @(negedge clk);
    n_total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h50)
      $display("FAIL late_latched_addr: got en %b addr %h want 1 00000050", mem_en, mem_addr);
    else n_pass++;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k == LAT && sb.size() != 0) begin
        e = sb.pop_front();
        n_total++;
        if (core_rvalid !== 1'b1 || core_rdata !== e.data)
          $display("FAIL late_core_done: got rvalid %b data %h want 1 %h",
                   core_rvalid, core_rdata, e.data);
        else n_pass++;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_read();
    test_latency1_read();
    test_ldr_write();
    test_back_to_back();
    test_late_arrival();
    n_total++;
    if (sb.size() !== 0) $display("FAIL sb_empty: got %0d entries want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
